// File: rtl/rf_pkg.sv
// Shared defaults for the register file and its read ports.
// Optional write-through bypass is selected with macro RF_BYPASS_EN.
package rf_pkg;

  localparam int RF_WORD_SIZE    = 32;
  localparam int RF_ADDRESS_SIZE = 4;
  localparam int RF_NUM_REGS     = 2 ** RF_ADDRESS_SIZE;

  localparam int RF_NUM_READ_PORTS = 2;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read path: register mux, optional write-through bypass
// (macro RF_BYPASS_EN), forced to zero while reset is asserted.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int WORD_SIZE    = RF_WORD_SIZE,
  parameter int ADDRESS_SIZE = RF_ADDRESS_SIZE
) (
  input  logic                                        rst,
  input  logic [ADDRESS_SIZE-1:0]                     addr,
  input  logic [2**ADDRESS_SIZE-1:0][WORD_SIZE-1:0]   regs,
  input  logic                                        wb_en,
  input  logic [ADDRESS_SIZE-1:0]                     wb_addr,
  input  logic [WORD_SIZE-1:0]                        wb_data,
  output logic [WORD_SIZE-1:0]                        data
);

`ifdef RF_BYPASS_EN
  always_comb begin
    data = regs[addr];
    if (wb_en && (addr == wb_addr)) begin
      data = wb_data;
    end
    if (rst) begin
      data = '0;
    end
  end
`else
  // Write-back inputs only feed the bypass; tie them off in this build.
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_addr, wb_data};

  always_comb begin
    data = regs[addr];
    if (rst) begin
      data = '0;
    end
  end
`endif

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file with asynchronous clear.
// Same-cycle write-through to the read ports is built in with macro RF_BYPASS_EN.
module register_file
  import rf_pkg::*;
#(
  parameter int WORD_SIZE    = RF_WORD_SIZE,
  parameter int ADDRESS_SIZE = RF_ADDRESS_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDRESS_SIZE-1:0] src1,
  input  logic [ADDRESS_SIZE-1:0] src2,
  input  logic [ADDRESS_SIZE-1:0] Dest_wb,
  input  logic [WORD_SIZE-1:0]    Result_WB,
  input  logic                    writeBackEn,
  output logic [WORD_SIZE-1:0]    reg1,
  output logic [WORD_SIZE-1:0]    reg2
);

  localparam int NUM_REGS = 2 ** ADDRESS_SIZE;

  logic [NUM_REGS-1:0][WORD_SIZE-1:0]          regs_reg;
  logic [RF_NUM_READ_PORTS-1:0][ADDRESS_SIZE-1:0] src_addr;
  logic [RF_NUM_READ_PORTS-1:0][WORD_SIZE-1:0]    rd_data;

  // Reset wins over a coincident write edge, so nothing lands during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_reg <= '0;
    end else if (writeBackEn) begin
      regs_reg[Dest_wb] <= Result_WB;
    end
  end

  assign src_addr[0] = src1;
  assign src_addr[1] = src2;

  genvar gi;
  generate
    for (gi = 0; gi < RF_NUM_READ_PORTS; gi++) begin : g_read
      rf_read_port #(
        .WORD_SIZE    (WORD_SIZE),
        .ADDRESS_SIZE (ADDRESS_SIZE)
      ) u_read_port (
        .rst     (rst),
        .addr    (src_addr[gi]),
        .regs    (regs_reg),
        .wb_en   (writeBackEn),
        .wb_addr (Dest_wb),
        .wb_data (Result_WB),
        .data    (rd_data[gi])
      );
    end
  endgenerate

  assign reg1 = rd_data[0];
  assign reg2 = rd_data[1];

endmodule

// File: tb/tb_register_file.sv
// Randomized self-checking bench for register_file (4-bit words, 16 entries).
// Expected visibility timing follows macro RF_BYPASS_EN.
module tb_register_file;

  localparam int W = 4;
  localparam int A = 4;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [A-1:0] src1 = '0;
  logic [A-1:0] src2 = '0;
  logic [A-1:0] Dest_wb = '0;
  logic [W-1:0] Result_WB = '0;
  logic         writeBackEn = 1'b0;
  logic [W-1:0] reg1;
  logic [W-1:0] reg2;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] mem [16];

  register_file #(.WORD_SIZE(W), .ADDRESS_SIZE(A)) dut (
    .clk         (clk),
    .rst         (rst),
    .src1        (src1),
    .src2        (src2),
    .Dest_wb     (Dest_wb),
    .Result_WB   (Result_WB),
    .writeBackEn (writeBackEn),
    .reg1        (reg1),
    .reg2        (reg2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference read: reset forces zero, bypass shows pending write, else stored value.
  function automatic logic [W-1:0] exp_rd(input logic [A-1:0] a);
    if (rst) return '0;
    if (BYP && writeBackEn && (a == Dest_wb)) return Result_WB;
    return mem[a];
  endfunction

  task automatic step(input logic we, input logic [A-1:0] dest, input logic [W-1:0] data,
                      input logic [A-1:0] s1, input logic [A-1:0] s2, input string tag);
    @(negedge clk);
    writeBackEn = we;
    Dest_wb     = dest;
    Result_WB   = data;
    src1        = s1;
    src2        = s2;
    #2;
    check({tag, "_pre1"}, reg1, exp_rd(s1));
    check({tag, "_pre2"}, reg2, exp_rd(s2));
    @(posedge clk);
    if (we && !rst) mem[dest] = data;
    #1;
    check({tag, "_post1"}, reg1, exp_rd(s1));
    check({tag, "_post2"}, reg2, exp_rd(s2));
  endtask

  initial begin
    logic [A-1:0] s1, s2, d;
    logic         we;

    // Reset pulse mid-cycle: outputs clear without waiting for an edge.
    src1 = 4'd0;
    src2 = 4'd1;
    #7;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    check("rst_async1", reg1, 4'd0);
    check("rst_async2", reg2, 4'd0);
    #99;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_rel1", reg1, 4'd0);
    check("rst_rel2", reg2, 4'd0);

    // Writes to address 0 then 1, including address 0 being writable.
    step(1'b1, 4'd0, 4'b1011, 4'd0, 4'd1, "wr0");
    step(1'b1, 4'd1, 4'b1011, 4'd0, 4'd1, "wr1");

    // Disabled write must not disturb anything.
    for (int i = 0; i < 3; i++) step(1'b0, 4'(i), 4'b0101, 4'd0, 4'd1, "nowr");

    // Address change and visibility timing on each port.
    step(1'b0, 4'd2, 4'b0101, 4'd2, 4'd3, "addr");
    step(1'b1, 4'd2, 4'b0101, 4'd2, 4'd3, "wr2");
    step(1'b1, 4'd3, 4'b0101, 4'd2, 4'd3, "wr3");

    // Same address on both ports, with a write to that address.
    step(1'b1, 4'd7, 4'b1110, 4'd7, 4'd7, "same");

    // Randomized traffic, biased toward reading the write destination.
    for (int i = 0; i < 300; i++) begin
      s1 = A'($urandom_range(0, 15));
      s2 = ($urandom_range(0, 7) == 0) ? s1 : A'($urandom_range(0, 15));
      d  = ($urandom_range(0, 2) == 0) ? s1 :
           ($urandom_range(0, 2) == 0) ? s2 : A'($urandom_range(0, 15));
      we = ($urandom_range(0, 3) != 0);
      step(we, d, W'($urandom_range(0, 15)), s1, s2, "rnd");
    end

    // Reset asserted during an active write: clears at once, no write lands.
    @(negedge clk);
    writeBackEn = 1'b1;
    Dest_wb     = 4'd5;
    Result_WB   = 4'b1111;
    src1        = 4'd5;
    src2        = 4'd0;
    #2;
    rst = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    #1;
    check("midrst1", reg1, 4'd0);
    check("midrst2", reg2, 4'd0);
    @(posedge clk);
    #1;
    check("midrst_edge1", reg1, 4'd0);
    check("midrst_edge2", reg2, 4'd0);
    @(negedge clk);
    writeBackEn = 1'b0;
    #1;
    rst = 1'b0;
    step(1'b0, 4'd5, 4'b1111, 4'd5, 4'd0, "after_rst");

    // Traffic resumes normally after the mid-operation reset.
    for (int i = 0; i < 40; i++) begin
      s1 = A'($urandom_range(0, 15));
      s2 = A'($urandom_range(0, 15));
      d  = ($urandom_range(0, 1) == 0) ? s2 : s1;
      step(1'b1, d, W'($urandom_range(0, 15)), s1, s2, "rnd2");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, meaning data width of each register in bits.
REQ-002 SHALL have parameter ADDRESS_SIZE, default 4, meaning address width; register count is 2**ADDRESS_SIZE.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all writes occur on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning reset; it is asynchronous and active-high.
REQ-005 SHALL have port src1, input, ADDRESS_SIZE bits, meaning read address for port 1.
REQ-006 SHALL have port src2, input, ADDRESS_SIZE bits, meaning read address for port 2.
REQ-007 SHALL have port Dest_wb, input, ADDRESS_SIZE bits, meaning write-back destination address.
REQ-008 SHALL have port Result_WB, input, WORD_SIZE bits, meaning write-back data.
REQ-009 SHALL have port writeBackEn, input, 1 bit, meaning write enable; 1 means write.
REQ-010 SHALL have port reg1, output, WORD_SIZE bits, meaning contents addressed by src1.
REQ-011 SHALL have port reg2, output, WORD_SIZE bits, meaning contents addressed by src2.

Function
REQ-012 SHALL hold 2**ADDRESS_SIZE registers of WORD_SIZE bits each; every address, including 0, is writable.
REQ-013 SHALL update register[Dest_wb] with Result_WB on each rising clk edge where writeBackEn=1 and rst=0.
REQ-014 SHALL leave all registers unchanged on an edge where writeBackEn=0, whatever Dest_wb and Result_WB are.
REQ-015 SHALL drive reg1 and reg2 combinationally from the addressed registers, with zero-cycle read latency and no clock involvement.
REQ-016 SHALL allow src1 = src2, with both outputs showing the same value.
REQ-017 SHALL make a written value visible on a matching read port no later than immediately after the write edge.
REQ-018 SHALL have no handshake, no X-propagation of unwritten entries, and no illegal-address case; all address values are in range.

Reset
REQ-019 SHALL clear every register to 0 immediately on rst going high, without waiting for a clock edge.
REQ-020 SHALL produce reg1 = reg2 = 0 while rst=1, for any addresses.
REQ-021 SHALL ignore writes while rst=1; the first write accepted is the first rising edge with rst=0.
REQ-022 SHALL clear all contents on a reset asserted mid-operation, with no partial write of the coincident edge.

Configuration
REQ-023 SHALL support macro RF_BYPASS_EN, which compiles write-through bypass in or out.
REQ-024 With RF_BYPASS_EN defined, when writeBackEn=1 and srcN=Dest_wb, regN SHALL equal Result_WB combinationally in the same cycle, before the edge; this applies independently to each port.
REQ-025 With RF_BYPASS_EN undefined, regN SHALL show only stored contents, so the new value appears after the write edge.
REQ-026 SHALL suppress the bypass while rst=1 in either build, so outputs stay 0.

Structure
REQ-027 SHALL place in shared package rf_pkg the default constants RF_WORD_SIZE=32, RF_ADDRESS_SIZE=4 and RF_NUM_REGS; the module parameters default from these.
REQ-028 SHALL implement each read path (mux plus optional bypass) in sub-module rf_read_port, instantiated twice, once for src1/reg1 and once for src2/reg2.

Verification (WORD_SIZE=4, ADDRESS_SIZE=4)
REQ-029 Reset scenario: with src1=0, src2=1, pulse rst high for 100 ns mid-cycle -> reg1=reg2=0 immediately, and they stay 0 after release.
REQ-030 Write scenario: Result_WB=4'b1011, writeBackEn=1, Dest_wb=0 for one edge, then Dest_wb=1 -> reg1=4'b1011 after the first edge and reg2=4'b1011 after the second.
REQ-031 Disabled write: writeBackEn=0, Result_WB=4'b0101 over several edges -> reg1 and reg2 stay 4'b1011.
REQ-032 Address change: src1=2, src2=3, then writes of 4'b0101 to addresses 2 and 3 -> outputs go from 0 to 4'b0101 per address; the timing is before or after the edge according to RF_BYPASS_EN.
REQ-033 Mid-operation reset: assert rst while writeBackEn=1 -> all outputs are 0 at once, and no write lands.
REQ-034 Run the bench in both builds, with RF_BYPASS_EN defined and undefined, and check same-cycle versus next-edge visibility on both ports.
